// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: 10/100 sample strobe, preamble/SFD lock, LSB-first
// byte assembly with carrier-drop toggle tolerance, jabber cut-off and frame statistics.
//
// state   | meaning
// IDLE    | no carrier, waiting for the first 01 preamble dibit
// PRE     | counting 01 preamble dibits, waiting for the 11 SFD dibit
// DATA    | assembling payload bytes until a double low carrier sample
// DISCARD | rejected or jabbering frame, waiting for end of carrier
module rmii_rx_deframer #(
    parameter int PRE_MIN   = 12,
    parameter int MAX_BYTES = 1536
) (
    input  logic        clk_50,
    input  logic        rx_reset_i,
    input  logic [1:0]  i_edutrxd,
    input  logic        i_edutrx_dv,
    input  logic        i_edutrx_er,
    input  logic        speed_10,
    output logic [7:0]  mii_rx_data_o,
    output logic        mii_rx_byte_received_o,
    output logic        mii_rx_frame_o,
    output logic        mii_rx_error_o,
    output logic [10:0] rx_byte_count_o,
    output logic [15:0] rx_frames_o,
    output logic [15:0] rx_drops_o
);

    typedef enum logic [1:0] {IDLE, PRE, DATA, DISCARD} state_t;

    localparam logic [4:0]  PRE_MIN_C = 5'(PRE_MIN);
    localparam logic [10:0] MAX_C     = 11'(MAX_BYTES);

    state_t      state_q, state_d;
    logic [4:0]  pre_cnt_q, pre_cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [5:0]  shift_q, shift_d;
    logic        low_q, low_d;
    logic [3:0]  div_q;
    logic        dv_prev_q;
    logic        smp;
    logic [7:0]  data_d;
    logic        strobe_d;
    logic        frame_d;
    logic        err_d;
    logic [10:0] bcnt_d;
    logic [15:0] frames_d;
    logic [15:0] drops_d;

    // At 10 Mb/s the divider is realigned to carrier rise so sampling lands mid-dibit.
    assign smp = speed_10 ? (div_q == 4'd4) : 1'b1;

    always_ff @(posedge clk_50) begin
        if (rx_reset_i) begin
            div_q     <= '0;
            dv_prev_q <= 1'b0;
        end else begin
            dv_prev_q <= i_edutrx_dv;
            if (state_q == IDLE && i_edutrx_dv && !dv_prev_q)
                div_q <= '0;
            else if (div_q == 4'd9)
                div_q <= '0;
            else
                div_q <= div_q + 4'd1;
        end
    end

    always_ff @(posedge clk_50) begin
        if (rx_reset_i) begin
            state_q                <= IDLE;
            pre_cnt_q              <= '0;
            idx_q                  <= '0;
            shift_q                <= '0;
            low_q                  <= 1'b0;
            mii_rx_data_o          <= '0;
            mii_rx_byte_received_o <= 1'b0;
            mii_rx_frame_o         <= 1'b0;
            mii_rx_error_o         <= 1'b0;
            rx_byte_count_o        <= '0;
            rx_frames_o            <= '0;
            rx_drops_o             <= '0;
        end else begin
            state_q                <= state_d;
            pre_cnt_q              <= pre_cnt_d;
            idx_q                  <= idx_d;
            shift_q                <= shift_d;
            low_q                  <= low_d;
            mii_rx_data_o          <= data_d;
            mii_rx_byte_received_o <= strobe_d;
            mii_rx_frame_o         <= frame_d;
            mii_rx_error_o         <= err_d;
            rx_byte_count_o        <= bcnt_d;
            rx_frames_o            <= frames_d;
            rx_drops_o             <= drops_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        low_d     = low_q;
        data_d    = mii_rx_data_o;
        strobe_d  = 1'b0;
        frame_d   = mii_rx_frame_o;
        err_d     = mii_rx_error_o;
        bcnt_d    = rx_byte_count_o;
        frames_d  = rx_frames_o;
        drops_d   = rx_drops_o;
        if (smp) begin
            case (state_q)
                IDLE: begin
                    low_d = 1'b0;
                    if (i_edutrx_dv && i_edutrxd == 2'b01) begin
                        state_d   = PRE;
                        pre_cnt_d = 5'd1;
                    end
                end
                PRE: begin
                    low_d = 1'b0;
                    if (!i_edutrx_dv) begin
                        state_d = IDLE;
                    end else if (i_edutrxd == 2'b01) begin
                        if (pre_cnt_q != 5'd31)
                            pre_cnt_d = pre_cnt_q + 5'd1;
                    end else if (i_edutrxd == 2'b11 && pre_cnt_q >= PRE_MIN_C) begin
                        state_d = DATA;
                        idx_d   = '0;
                        bcnt_d  = '0;
                        err_d   = 1'b0;
                        frame_d = 1'b1;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                DATA: begin
                    if (i_edutrx_er)
                        err_d = 1'b1;
                    if (i_edutrx_dv) begin
                        low_d = 1'b0;
                        if (rx_byte_count_o == MAX_C) begin
                            err_d   = 1'b1;
                            frame_d = 1'b0;
                            drops_d = rx_drops_o + 16'd1;
                            state_d = DISCARD;
                        end else begin
                            shift_d = {i_edutrxd, shift_q[5:2]};
                            idx_d   = idx_q + 2'd1;
                            if (idx_q == 2'd3) begin
                                data_d   = {i_edutrxd, shift_q};
                                strobe_d = 1'b1;
                                bcnt_d   = rx_byte_count_o + 11'd1;
                            end
                        end
                    end else if (low_q) begin
                        // Second consecutive low sample: genuine end of carrier.
                        state_d = IDLE;
                        frame_d = 1'b0;
                        low_d   = 1'b0;
                        if (idx_q != 2'd0) begin
                            err_d   = 1'b1;
                            drops_d = rx_drops_o + 16'd1;
                        end else if (!mii_rx_error_o) begin
                            frames_d = rx_frames_o + 16'd1;
                        end else begin
                            drops_d = rx_drops_o + 16'd1;
                        end
                    end else begin
                        low_d = 1'b1;
                    end
                end
                DISCARD: begin
                    if (i_edutrx_dv) begin
                        low_d = 1'b0;
                    end else if (low_q) begin
                        state_d = IDLE;
                        low_d   = 1'b0;
                    end else begin
                        low_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Randomized bench for rmii_rx_deframer: frames are built from byte lists and
// the expected bytes/statistics are derived from frame-level rules.
module tb_rmii_rx_deframer;
    localparam int MAX_BYTES = 1536;
    localparam int PRE_MIN   = 12;

    logic        clk_50 = 1'b0;
    logic        rx_reset_i;
    logic [1:0]  i_edutrxd;
    logic        i_edutrx_dv;
    logic        i_edutrx_er;
    logic        speed_10;
    logic [7:0]  mii_rx_data_o;
    logic        mii_rx_byte_received_o;
    logic        mii_rx_frame_o;
    logic        mii_rx_error_o;
    logic [10:0] rx_byte_count_o;
    logic [15:0] rx_frames_o;
    logic [15:0] rx_drops_o;

    rmii_rx_deframer #(.PRE_MIN(PRE_MIN), .MAX_BYTES(MAX_BYTES)) dut (
        .clk_50                 (clk_50),
        .rx_reset_i             (rx_reset_i),
        .i_edutrxd              (i_edutrxd),
        .i_edutrx_dv            (i_edutrx_dv),
        .i_edutrx_er            (i_edutrx_er),
        .speed_10               (speed_10),
        .mii_rx_data_o          (mii_rx_data_o),
        .mii_rx_byte_received_o (mii_rx_byte_received_o),
        .mii_rx_frame_o         (mii_rx_frame_o),
        .mii_rx_error_o         (mii_rx_error_o),
        .rx_byte_count_o        (rx_byte_count_o),
        .rx_frames_o            (rx_frames_o),
        .rx_drops_o             (rx_drops_o)
    );

    always #10 clk_50 = ~clk_50;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int frame_hi = 0;
    logic [7:0] got_q[$];
    int         got_t[$];
    logic [7:0] payload[$];
    logic [15:0] exp_frames;
    logic [15:0] exp_drops;
    logic [10:0] exp_count;
    logic        exp_err;
    int base_idx;
    int base_hi;

    always @(negedge clk_50) begin
        cyc++;
        if (mii_rx_byte_received_o) begin
            got_q.push_back(mii_rx_data_o);
            got_t.push_back(cyc);
        end
        if (mii_rx_frame_o)
            frame_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_data"},   32'(mii_rx_data_o), 0);
        chk({pfx, "_strobe"}, 32'(mii_rx_byte_received_o), 0);
        chk({pfx, "_frame"},  32'(mii_rx_frame_o), 0);
        chk({pfx, "_error"},  32'(mii_rx_error_o), 0);
        chk({pfx, "_count"},  32'(rx_byte_count_o), 0);
        chk({pfx, "_frames"}, 32'(rx_frames_o), 0);
        chk({pfx, "_drops"},  32'(rx_drops_o), 0);
    endtask

    task automatic send(input logic v, input logic [1:0] d, input logic e);
        i_edutrx_dv = v;
        i_edutrxd   = d;
        i_edutrx_er = e;
        repeat (speed_10 ? 10 : 1) @(negedge clk_50);
    endtask

    task automatic send_frame(input int pre_len, input int n_extra, input int tog_pct,
                              input int er_at, input bit final_tog);
        int nb;
        int k;
        nb = payload.size();
        k = 0;
        base_idx = got_q.size();
        base_hi  = frame_hi;
        for (int i = 0; i < pre_len; i++) send(1'b1, 2'b01, 1'b0);
        send(1'b1, 2'b11, 1'b0);
        for (int bi = 0; bi < nb; bi++) begin
            for (int j = 0; j < 4; j++) begin
                logic [7:0] b;
                logic [1:0] d;
                b = payload[bi];
                d = b[2*j +: 2];
                // A lone low sample carries the inverted dibit so a wrong shift is visible.
                if ((k > 0 && int'($urandom_range(99)) < tog_pct) || (final_tog && bi == nb - 1 && j >= 2))
                    send(1'b0, ~d, 1'b0);
                send(1'b1, d, k == er_at);
                if (bi == MAX_BYTES && j == 0) begin
                    chk("jabber_frame_low", 32'(mii_rx_frame_o), 0);
                    chk("jabber_error", 32'(mii_rx_error_o), 1);
                end
                k++;
            end
        end
        for (int i = 0; i < n_extra; i++) send(1'b1, 2'($urandom), 1'b0);
        repeat (5) send(1'b0, 2'b00, 1'b0);
    endtask

    task automatic finish_frame(input string tag, input int pre_len, input int n_extra, input int er_at);
        bit acc;
        bit jab;
        int nb;
        int n_exp;
        int n_got;
        int bad;
        acc = pre_len >= PRE_MIN;
        nb = payload.size();
        n_exp = 0;
        bad = 0;
        if (acc) begin
            jab = (4 * nb + n_extra) > 4 * MAX_BYTES;
            n_exp = jab ? MAX_BYTES : nb;
            exp_count = 11'(n_exp);
            exp_err = jab || (n_extra % 4 != 0) || (er_at >= 0 && er_at < 4 * n_exp);
            if (exp_err) exp_drops++;
            else exp_frames++;
        end
        n_got = got_q.size() - base_idx;
        chk({tag, "_nbytes"}, 32'(n_got), 32'(n_exp));
        for (int i = 0; i < n_exp && i < n_got; i++)
            if (got_q[base_idx + i] !== payload[i]) bad++;
        chk({tag, "_bytes_bad"}, 32'(bad), 0);
        chk({tag, "_frame_seen"}, 32'(frame_hi != base_hi), 32'(acc));
        chk({tag, "_frame_low"}, 32'(mii_rx_frame_o), 0);
        chk({tag, "_error"}, 32'(mii_rx_error_o), 32'(exp_err));
        chk({tag, "_count"}, 32'(rx_byte_count_o), 32'(exp_count));
        chk({tag, "_frames"}, 32'(rx_frames_o), 32'(exp_frames));
        chk({tag, "_drops"}, 32'(rx_drops_o), 32'(exp_drops));
    endtask

    task automatic rand_payload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
    endtask

    initial begin
        int bad;
        int nb;
        int pre;
        int extra;
        int er_at;
        rx_reset_i = 1'b1;
        i_edutrx_dv = 1'b0;
        i_edutrxd = 2'b00;
        i_edutrx_er = 1'b0;
        speed_10 = 1'b0;
        exp_frames = '0;
        exp_drops = '0;
        exp_count = '0;
        exp_err = 1'b0;
        repeat (4) @(negedge clk_50);
        chk_zero("reset");
        rx_reset_i = 1'b0;
        repeat (3) send(1'b0, 2'b00, 1'b0);

        payload = '{8'h55, 8'hD5, 8'hA3};
        send_frame(31, 0, 0, -1, 1'b0);
        finish_frame("t1_100m", 31, 0, -1);

        speed_10 = 1'b1;
        send_frame(31, 0, 0, -1, 1'b0);
        finish_frame("t2_10m", 31, 0, -1);
        bad = 0;
        for (int i = base_idx + 1; i < got_q.size(); i++)
            if (got_t[i] - got_t[i-1] != 40) bad++;
        chk("t2_spacing_bad", 32'(bad), 0);
        speed_10 = 1'b0;

        send_frame(6, 0, 0, -1, 1'b0);
        finish_frame("t3_short_pre", 6, 0, -1);
        send_frame(11, 0, 0, -1, 1'b0);
        finish_frame("pre_11", 11, 0, -1);
        send_frame(12, 0, 0, -1, 1'b0);
        finish_frame("pre_12", 12, 0, -1);

        rand_payload(2);
        send_frame(20, 1, 0, -1, 1'b0);
        finish_frame("t4_misalign", 20, 1, -1);

        rand_payload(3);
        send_frame(16, 0, 0, -1, 1'b1);
        finish_frame("t5_toggle", 16, 0, -1);

        for (int f = 0; f < 40; f++) begin
            speed_10 = (f % 8 == 7);
            nb = speed_10 ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 16));
            rand_payload(nb);
            pre = int'($urandom_range(8, 31));
            extra = ($urandom_range(4) == 0) ? int'($urandom_range(1, 3)) : 0;
            er_at = ($urandom_range(5) == 0) ? int'($urandom_range(0, 4 * nb - 1)) : -1;
            send_frame(pre, extra, 15, er_at, 1'b0);
            finish_frame("rand", pre, extra, er_at);
        end
        speed_10 = 1'b0;

        rand_payload(1600);
        send_frame(20, 0, 0, -1, 1'b0);
        finish_frame("t6_jabber", 20, 0, -1);
        rand_payload(4);
        send_frame(14, 0, 0, -1, 1'b0);
        finish_frame("after_jabber", 14, 0, -1);

        repeat (15) send(1'b1, 2'b01, 1'b0);
        send(1'b1, 2'b11, 1'b0);
        repeat (10) send(1'b1, 2'($urandom), 1'b0);
        rx_reset_i = 1'b1;
        @(negedge clk_50);
        chk_zero("mid_reset");
        i_edutrx_dv = 1'b0;
        @(negedge clk_50);
        rx_reset_i = 1'b0;
        exp_frames = '0;
        exp_drops = '0;
        exp_count = '0;
        exp_err = 1'b0;
        repeat (3) send(1'b0, 2'b00, 1'b0);
        rand_payload(5);
        send_frame(13, 0, 0, -1, 1'b0);
        finish_frame("after_reset", 13, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rmii_rx_deframer.md
Name: rmii_rx_deframer

Overview:
- Upstream receive front-end for the Ethernet framing block's MII receive inputs.
- Samples RMII dibits from the PHY and locks onto preamble/SFD.
- Assembles LSB-first bytes and presents them as a byte-strobed stream with frame and error qualifiers.
- Supports 100 Mb/s (one dibit per clock) and 10 Mb/s (one dibit per 10 clocks); keeps per-frame byte count and drop statistics.

Parameters:
- PRE_MIN, 12: minimum count of consecutive 01 dibits required before the 11 SFD dibit.
- MAX_BYTES, 1536: jabber limit in bytes per frame; must fit in 11 bits.

Ports:
- clk_50  in  1  RMII reference clock; the block's only clock.
- rx_reset_i  in  1  synchronous, active-high reset.
- i_edutrxd  in  2  RMII receive dibit.
- i_edutrx_dv  in  1  RMII CRS_DV.
- i_edutrx_er  in  1  RMII RX_ER.
- speed_10  in  1  1 = 10 Mb/s sampling, 0 = 100 Mb/s; change only while no frame is in progress.
- mii_rx_data_o  out  8  assembled byte.
- mii_rx_byte_received_o  out  1  one-cycle strobe; mii_rx_data_o is valid on this cycle.
- mii_rx_frame_o  out  1  high for the duration of the frame payload.
- mii_rx_error_o  out  1  sticky error for the current frame.
- rx_byte_count_o  out  11  bytes delivered in the current or last frame.
- rx_frames_o  out  16  count of good frames (wraps).
- rx_drops_o  out  16  count of aborted frames (wraps).

Behaviour:
- Interface: one clock, clk_50; reset is synchronous and active-high (rx_reset_i). Reset clears all outputs, counters and state to 0 (state IDLE).
- Sample strobe (smp):
  - speed_10=0: smp=1 every cycle.
  - speed_10=1: a mod-10 counter clears on the i_edutrx_dv rising edge while in IDLE, and smp=1 when the counter equals 4.
  - All state and dibit logic below advances only on smp.
- FSM states:
  - IDLE: i_edutrx_dv=1 and rxd=01 -> PRE with pre_cnt=1. i_edutrx_dv=1 and rxd=00 -> stay.
  - PRE:
    - rxd=01 -> pre_cnt++, saturating at 31.
    - rxd=11 and pre_cnt>=PRE_MIN -> DATA, with dibit index=0 and byte count=0.
    - rxd=11 and pre_cnt<PRE_MIN -> DISCARD.
    - rxd=00 or 10 -> DISCARD.
    - i_edutrx_dv=0 -> IDLE.
    - No statistics change on any PRE exit.
  - DATA:
    - Each smp with i_edutrx_dv=1 shifts the dibit into bits [2k+1:2k], where k=dibit index 0..3; the first dibit lands in [1:0].
    - On k=3, the byte is registered to mii_rx_data_o and mii_rx_byte_received_o pulses for exactly one clk_50 cycle, on the cycle after that sample. Count increments at the same edge.
  - DISCARD: wait for end of carrier (two consecutive smp with i_edutrx_dv=0) -> IDLE.
- mii_rx_frame_o: rises on the cycle after the SFD sample; falls on the cycle after end detection.
- End detection in DATA:
  - i_edutrx_dv=0 on two consecutive smp -> frame end. A single low sample followed by high is the RMII carrier-drop toggle; the dibit on the low sample is discarded, not shifted.
  - At end, dibit index != 0 (misaligned) -> set mii_rx_error_o and count a drop.
  - Else, if the error flag is clear -> rx_frames_o++, otherwise rx_drops_o++.
  - Then IDLE. mii_rx_error_o clears when the next frame enters DATA.
- i_edutrx_er=1 in DATA on any smp sets mii_rx_error_o; byte delivery continues.
- Jabber: byte count reaching MAX_BYTES while i_edutrx_dv is still high:
  - set the error flag, drop mii_rx_frame_o, count a drop, -> DISCARD.
- rx_byte_count_o holds its final value until the next SFD.
- Reset mid-frame: immediate IDLE with all outputs 0 on the next edge; no count updates.
- Counter wrap: 0xFFFF+1 -> 0x0000.

Test Plan:
1. 100M, 31 dibits of 01 + 11, then bytes 0x55,0xD5,0xA3 (dibits LSB first), then two dv-low samples:
   - strobes carry 0x55,0xD5,0xA3;
   - rx_byte_count_o=3, rx_frames_o=1, mii_rx_error_o=0.
2. Same frame with speed_10=1 and each dibit held 10 clocks:
   - identical byte sequence;
   - strobes spaced 40 clocks apart.
3. Preamble of only 6 dibits of 01 then 11:
   - no strobes, mii_rx_frame_o never rises, all counters unchanged.
4. Frame of 2 bytes + 1 extra dibit, then dv low:
   - 2 strobes, mii_rx_error_o=1, rx_drops_o=1.
5. In DATA, dv pattern 0,1,0,1 at nibble boundaries during final byte, then 0,0:
   - no spurious frame end until the double low;
   - toggle-low dibits are not shifted into the byte;
   - frame counted good.
6. Jabber with MAX_BYTES=1536: frame of 1600 bytes:
   - exactly 1536 strobes, then mii_rx_frame_o=0 and mii_rx_error_o=1;
   - rx_drops_o=1, state IDLE after dv drops.
   - Also assert rx_reset_i mid-frame: all outputs read 0 on the next cycle.
